// File: rtl/gray_step_arbiter_pkg.sv
// Shared encodings and constants for the gray-counter burst arbiter.
package gray_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } arb_state_t;

  localparam logic [7:0] OVF_CNT_MAX = 8'd255;

endpackage

// File: rtl/gray_step_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the shared gray unit.
interface gray_step_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4
);
  logic [N_REQ-1:0]       Req;
  logic [N_REQ*LEN_W-1:0] Len;
  logic                   Gray_Overflow;
  logic                   Gray_En;
  logic [N_REQ-1:0]       Grant;
  logic [N_REQ-1:0]       Done;
  logic                   Done_Ovf;
  logic [7:0]             Ovf_Count;

  modport master (
    output Req, Len, Gray_Overflow,
    input  Gray_En, Grant, Done, Done_Ovf, Ovf_Count
  );

  modport slave (
    input  Req, Len, Gray_Overflow,
    output Gray_En, Grant, Done, Done_Ovf, Ovf_Count
  );
endinterface

// File: rtl/gray_step_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    // i == N revisits ptr itself, so the last owner wins only when alone
    for (int i = 1; i <= N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_step_arbiter.sv
// Non-preemptive round-robin arbiter that runs the shared gray counter
// for a requested number of steps and reports completion and wraps.
//
// state | meaning
// IDLE  | no owner; arbitrate among Req, latch winner's length
// RUN   | Gray_En high, one counter step per cycle until rem reaches 1
// DONE  | one-cycle Done pulse to owner; pointer moves to owner
module gray_step_arbiter
  import gray_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4
) (
  input logic               Clk,
  input logic               Reset,
  gray_step_arbiter_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state, state_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic [N_REQ-1:0] grant, grant_nxt;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_vld;
  logic [PW-1:0]    ptr, ptr_nxt;
  logic [PW-1:0]    win_idx, own_idx;
  logic             burst_ovf, burst_ovf_nxt;
  logic [7:0]       ovf_cnt, ovf_cnt_nxt;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req   (bus.Req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  always_comb begin
    win_idx = '0;
    own_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) win_idx = PW'(i);
      if (grant[i])    own_idx = PW'(i);
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      rem       <= '0;
      grant     <= '0;
      ptr       <= PW'(N_REQ - 1);
      burst_ovf <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      grant     <= grant_nxt;
      ptr       <= ptr_nxt;
      burst_ovf <= burst_ovf_nxt;
      ovf_cnt   <= ovf_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    rem_nxt       = rem;
    grant_nxt     = grant;
    ptr_nxt       = ptr;
    burst_ovf_nxt = burst_ovf;
    ovf_cnt_nxt   = ovf_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          rem_nxt       = bus.Len[int'(win_idx)*LEN_W +: LEN_W];
          grant_nxt     = pick_gnt;
          burst_ovf_nxt = 1'b0;
          state_nxt     = (rem_nxt != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        rem_nxt = rem - LEN_W'(1);
        if (bus.Gray_Overflow) begin
          burst_ovf_nxt = 1'b1;
          if (ovf_cnt != OVF_CNT_MAX) ovf_cnt_nxt = ovf_cnt + 8'd1;
        end
        if (rem == LEN_W'(1)) state_nxt = DONE;
      end
      DONE: begin
        ptr_nxt   = own_idx;
        grant_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.Gray_En   = (state == RUN);
  assign bus.Grant     = grant;
  assign bus.Done      = (state == DONE) ? grant : '0;
  assign bus.Done_Ovf  = (state == DONE) && burst_ovf;
  assign bus.Ovf_Count = ovf_cnt;

endmodule

// File: tb/tb_gray_step_arbiter.sv
// Directed bench: arbiter plus a behavioural 3-bit gray counter on its enable.
module tb_gray_step_arbiter;
  localparam int N_REQ = 4;
  localparam int LEN_W = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  logic gray_rst = 1'b0;
  logic [2:0] gcnt;
  logic [2:0] gray_out;

  int n_chk = 0;
  int n_err = 0;

  int cyc, en_cnt, grant_cyc, done_cnt, dovf_cnt, onehot_err;
  int done_q[$];
  int done_at[$];
  int rise_at[$];
  logic [N_REQ-1:0] prev_grant;

  gray_step_arbiter_if #(.N_REQ(N_REQ), .LEN_W(LEN_W)) bus ();

  gray_step_arbiter #(.N_REQ(N_REQ), .LEN_W(LEN_W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Gray unit model: binary count, gray-coded output, Overflow on the wrap step
  always_ff @(posedge Clk or negedge gray_rst) begin
    if (!gray_rst) gcnt <= 3'd0;
    else if (bus.Gray_En) gcnt <= gcnt + 3'd1;
  end
  assign gray_out          = gcnt ^ (gcnt >> 1);
  assign bus.Gray_Overflow = (gcnt == 3'd7);

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic clr_mon();
    cyc = 0; en_cnt = 0; grant_cyc = 0; done_cnt = 0; dovf_cnt = 0; onehot_err = 0;
    done_q.delete(); done_at.delete(); rise_at.delete();
    prev_grant = bus.Grant;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
    if (bus.Gray_En) en_cnt++;
    if (bus.Grant != '0) grant_cyc++;
    if ($countones(bus.Grant) > 1) onehot_err++;
    if (bus.Grant != '0 && prev_grant == '0) rise_at.push_back(cyc);
    if (bus.Done != '0) begin
      done_cnt++;
      done_at.push_back(cyc);
      for (int i = 0; i < N_REQ; i++) if (bus.Done[i]) done_q.push_back(i);
      if (bus.Done_Ovf) dovf_cnt++;
    end
    prev_grant = bus.Grant;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    gray_rst = 1'b0;
    @(posedge Clk);
    #3;
    Reset = 1'b1;
    gray_rst = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Req = '0;
    bus.Len = '0;
    #12;
    check_val("rst_en",    bus.Gray_En,   0);
    check_val("rst_grant", bus.Grant,     0);
    check_val("rst_done",  bus.Done,      0);
    check_val("rst_dovf",  bus.Done_Ovf,  0);
    check_val("rst_ovfc",  bus.Ovf_Count, 0);
    do_reset();

    // single burst, Len0=5
    bus.Req = 4'b0001;
    bus.Len = 16'h0005;
    clr_mon();
    tick();
    check_val("t1_grant_c1", bus.Grant, 4'b0001);
    check_val("t1_en_c1", bus.Gray_En, 1);
    bus.Req = '0;
    repeat (7) tick();
    check_val("t1_en_cnt", en_cnt, 5);
    check_val("t1_grant_cyc", grant_cyc, 6);
    check_val("t1_done_cnt", done_cnt, 1);
    check_val("t1_done_at", qget(done_at, 0), 6);
    check_val("t1_done_who", qget(done_q, 0), 0);
    check_val("t1_dovf", dovf_cnt, 0);
    check_val("t1_gray", gray_out, 3'b111);
    check_val("t1_ovfc", bus.Ovf_Count, 0);

    // all requesting, Len=2 each, round-robin order
    do_reset();
    bus.Req = 4'b1111;
    bus.Len = 16'h2222;
    clr_mon();
    repeat (20) tick();
    bus.Req = '0;
    repeat (3) tick();
    check_val("t2_en_cnt", en_cnt, 10);
    check_val("t2_done_cnt", done_cnt, 5);
    for (int j = 0; j < 5; j++) begin
      check_val($sformatf("t2_order%0d", j), qget(done_q, j), j % 4);
      check_val($sformatf("t2_done_at%0d", j), qget(done_at, j), 3 + 4*j);
      check_val($sformatf("t2_rise_at%0d", j), qget(rise_at, j), 1 + 4*j);
    end
    check_val("t2_onehot", onehot_err, 0);

    // wrap accounting from gray 000
    do_reset();
    bus.Len = 16'h000A;
    clr_mon();
    bus.Req = 4'b0001; tick(); bus.Req = '0; repeat (11) tick();
    check_val("t3_en_cnt", en_cnt, 10);
    check_val("t3_done_at", qget(done_at, 0), 11);
    check_val("t3_dovf", dovf_cnt, 1);
    check_val("t3_ovfc1", bus.Ovf_Count, 1);
    check_val("t3_gray", gray_out, 3'b011);
    bus.Req = 4'b0001; tick(); bus.Req = '0; repeat (11) tick();
    check_val("t3_ovfc2", bus.Ovf_Count, 2);
    for (int b = 0; b < 300; b++) begin
      bus.Req = 4'b0001; tick(); bus.Req = '0; repeat (11) tick();
    end
    check_val("t3_ovfc_sat", bus.Ovf_Count, 255);
    clr_mon();
    bus.Req = 4'b0001; tick(); bus.Req = '0; repeat (11) tick();
    check_val("t3_ovfc_hold", bus.Ovf_Count, 255);
    check_val("t3_dovf_sat", dovf_cnt, 1);
    check_val("t3_done_sat", done_cnt, 1);

    // zero-length burst on requester 2
    bus.Len = 16'h0000;
    bus.Req = 4'b0100;
    clr_mon();
    tick();
    check_val("t4_grant", bus.Grant, 4'b0100);
    check_val("t4_done", bus.Done, 4'b0100);
    bus.Req = '0;
    repeat (3) tick();
    check_val("t4_en_cnt", en_cnt, 0);
    check_val("t4_grant_cyc", grant_cyc, 1);
    check_val("t4_done_cnt", done_cnt, 1);

    // reset during RUN at step 3 of a Len=8 burst
    bus.Len = 16'h0008;
    bus.Req = 4'b0001;
    clr_mon();
    tick();
    bus.Req = '0;
    tick(); tick();
    check_val("t5_en_pre", bus.Gray_En, 1);
    Reset = 1'b0;
    #1;
    check_val("t5_en_rst", bus.Gray_En, 0);
    check_val("t5_grant_rst", bus.Grant, 0);
    check_val("t5_done_rst", bus.Done, 0);
    repeat (3) tick();
    check_val("t5_no_done", done_cnt, 0);
    Reset = 1'b1;
    check_val("t5_ovfc_rst", bus.Ovf_Count, 0);
    bus.Len = 16'h0011;
    bus.Req = 4'b0011;
    clr_mon();
    tick();
    check_val("t5_first", bus.Grant, 4'b0001);
    repeat (5) tick();
    bus.Req = '0;
    repeat (2) tick();
    check_val("t5_done_cnt", done_cnt, 2);
    check_val("t5_order0", qget(done_q, 0), 0);
    check_val("t5_order1", qget(done_q, 1), 1);

    // Req1 dropped mid-burst, Req3 rises meanwhile
    bus.Len = 16'h1060;
    bus.Req = 4'b0010;
    clr_mon();
    tick();
    check_val("t6_grant", bus.Grant, 4'b0010);
    tick();
    bus.Req = 4'b1000;
    repeat (7) tick();
    bus.Req = '0;
    repeat (3) tick();
    check_val("t6_en_cnt", en_cnt, 7);
    check_val("t6_done_cnt", done_cnt, 2);
    check_val("t6_order0", qget(done_q, 0), 1);
    check_val("t6_done_at0", qget(done_at, 0), 7);
    check_val("t6_order1", qget(done_q, 1), 3);
    check_val("t6_rise3", qget(rise_at, 1), 9);
    check_val("t6_onehot", onehot_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
